logic_reduce_unit: RTL and testbench
====================================

Name: logic_reduce_unit

Overview:
- Parametrised, registered successor to the single two-input gate.
- Applies a selectable bitwise op (AND/OR/XOR/NAND) to WIDTH-bit operand pairs.
- Two modes:
  - Elementwise: one result per input beat.
  - Reduce: folds a burst of beats into one result.
- Sits between operand producers and the register/ALU datapath, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 4, width of the beat counter out_count (>=1).
- MAX_BURST, 15, max beats folded in reduce mode before forced emit (1..2^CNT_W-1).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_last  in  1  last beat of burst (reduce mode only; ignored in elementwise mode).
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NAND.
- mode  in  1  0 elementwise, 1 reduce.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_count  out  CNT_W  beats contributing to out_data.
- out_trunc  out  1  reduce burst cut at MAX_BURST without in_last.

Behaviour:
- Reset (clk edge with rst_n=0):
  - out_valid=0, out_data=0, out_count=0, out_trunc=0, state=IDLE.
  - in_ready is 0 while rst_n=0.
  - Reset mid-burst discards the partial accumulator; no output is produced.
- Handshakes:
  - Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
  - out_data, out_count and out_trunc are stable while out_valid=1 and out_ready=0.
- Elementwise result: e = op(in_a, in_b), where NAND = ~(a&b).
- Operation sampling: mode and op are sampled on the first accepted beat of a burst (the IDLE accept) and held in op_q/mode_q. Changes mid-burst are ignored.
- FSM IDLE:
  - in_ready = !out_valid | out_ready.
  - On accept with mode=0: load out_data=e, out_count=1, out_trunc=0, out_valid=1 next cycle (latency 1). Stay in IDLE.
  - Full throughput: accept and emit in the same cycle is allowed when out_ready=1.
  - On accept with mode=1: acc=e, cnt=1.
    - If in_last=1 or MAX_BURST=1: emit immediately (as below) and stay in IDLE.
    - Otherwise go to ACCUM.
- FSM ACCUM:
  - in_ready=1.
  - Each accept computes acc = acc COMB e.
    - COMB is AND for op_q 00 and 11.
    - COMB is OR for 01.
    - COMB is XOR for 10.
    - NAND therefore folds as AND of the per-beat NANDs.
  - cnt increments on each accept.
  - Emit when in_last=1, or when cnt reaches MAX_BURST (out_trunc=1 if in_last=0).
  - Emit means:
    - If out_valid=0 or out_ready=1: load outputs, go to IDLE.
    - Otherwise go to HOLD with the result staged internally.
  - After a truncated emit, beats up to the next in_last start a new burst (the first is sampled in IDLE).
- FSM HOLD:
  - in_ready=0.
  - When out_ready=1: the old result retires and the staged result loads into the output regs the next cycle. Go to IDLE.
- Boundaries:
  - out_count never exceeds MAX_BURST.
  - in_last=1 on a single-beat reduce burst gives out_count=1.
  - in_valid=0 gaps inside a burst are legal; the accumulator holds.
  - out_ready=0 stalls upstream via in_ready; no beat is dropped or duplicated.

Optional Feature:
- Macro LOGIC_REDUCE_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = ^out_data.
  - Registered with out_data and held under stall.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then mode=0, op=00, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_valid=1, out_data=8'h30, out_count=1.
- mode=0, back-to-back beats with op 01/10/11 on a=8'hA5, b=8'h0F -> 8'hAF, 8'hAA, 8'hFA on consecutive cycles; in_ready stays 1.
- mode=1, op=10, 3 beats (a,b) = (01,00), (02,00), (04,00) with in_last on the third -> single out_data=8'h07, out_count=3, out_trunc=0.
- mode=1, op=00, MAX_BURST=15, 16 beats of (FF,FF) with in_last only on the 16th -> first emit out_count=15, out_trunc=1. The 16th beat emits out_count=1, out_trunc=0.
- Reduce burst ends while out_ready=0 with a prior result pending -> HOLD, in_ready=0; both results delivered in order once out_ready=1; nothing lost.
- rst_n=0 mid-burst after 2 beats -> out_valid=0 and no partial result after reset. With LOGIC_REDUCE_PARITY_EN: result 8'h07 -> out_parity=1.

Source files
------------

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: registered AND/OR/XOR/NAND, elementwise or burst reduce.
// Define LOGIC_REDUCE_PARITY_EN to add the registered out_parity port.
module logic_reduce_unit #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_BURST = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic [1:0]       op,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
`ifdef LOGIC_REDUCE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [WIDTH-1:0] gate_f(
    input logic [1:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    unique case (o)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = a ^ b;
      2'b11: r = ~(a & b);
    endcase
    return r;
  endfunction

  // NAND bursts fold with AND over the per-beat NAND values
  function automatic logic [WIDTH-1:0] fold_f(
    input logic [1:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] e
  );
    logic [WIDTH-1:0] r;
    unique case (o)
      2'b01:   r = a | e;
      2'b10:   r = a ^ e;
      default: r = a & e;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic [CNT_W-1:0] oc_q, oc_d;
  logic             ot_q, ot_d;

  logic [WIDTH-1:0] sd_q, sd_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic             st_q, st_d;

  logic             in_fire;
  logic             can_load;
  logic             is_idle;
  logic             emit;
  logic             rdy;
  logic [1:0]       op_eff;
  logic [WIDTH-1:0] elem;
  logic [WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_cnt;
  logic             res_trunc;

  always_comb begin
    in_fire   = in_valid & in_ready;
    can_load  = ~ov_q | out_ready;
    is_idle   = (state_q == IDLE);
    op_eff    = is_idle ? op : op_q;
    elem      = gate_f(op_eff, in_a, in_b);
    res_data  = is_idle ? elem
                        : fold_f(op_q, acc_q, elem);
    res_cnt   = is_idle ? ONE : cnt_q + ONE;
    res_trunc = ~in_last & (~is_idle | mode);
    emit      = 1'b0;
    unique case (state_q)
      IDLE:
        emit = in_fire &
               (~mode | in_last | (MAXC == ONE));
      ACCUM:
        emit = in_fire &
               (in_last | (res_cnt == MAXC));
      default: emit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (in_fire & mode & ~emit) state_d = ACCUM;
      ACCUM:
        if (emit) state_d = can_load ? IDLE : HOLD;
      HOLD:
        if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      IDLE:    rdy = can_load;
      ACCUM:   rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
    in_ready = rst_n & rdy;
  end

  always_comb begin
    ov_d   = ov_q & ~out_ready;
    od_d   = od_q;
    oc_d   = oc_q;
    ot_d   = ot_q;
    sd_d   = sd_q;
    sc_d   = sc_q;
    st_d   = st_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    mode_d = mode_q;
    if (in_fire) begin
      acc_d = res_data;
      cnt_d = res_cnt;
    end
    if (in_fire & is_idle) begin
      op_d   = op;
      mode_d = mode;
    end
    if (state_q == HOLD && out_ready) begin
      ov_d = 1'b1;
      od_d = sd_q;
      oc_d = sc_q;
      ot_d = st_q;
    end else if (emit && can_load) begin
      ov_d = 1'b1;
      od_d = res_data;
      oc_d = res_cnt;
      ot_d = res_trunc;
    end
    // consumer still holds the previous result
    if (emit && !can_load) begin
      sd_d = res_data;
      sc_d = res_cnt;
      st_d = res_trunc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oc_q    <= '0;
      ot_q    <= 1'b0;
      sd_q    <= '0;
      sc_q    <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
      ot_q    <= ot_d;
      sd_q    <= sd_d;
      sc_q    <= sc_d;
      st_q    <= st_d;
    end
  end

`ifdef LOGIC_REDUCE_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^od_d;
  end

  assign out_parity = par_q;
`endif

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_count = oc_q;
  assign out_trunc = ot_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: directed and randomized checks of logic_reduce_unit
// against a burst-level reference model.
module tb_logic_reduce_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic [1:0] op;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_trunc;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic       out_parity;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] c;
    logic       t;
  } res_t;

  res_t       exp_q[$];
  res_t       got_q[$];
  logic [7:0] bq[$];
  logic [1:0] bop;
  bit         bopen = 0;
  res_t       mon_x;
  res_t       cur;
  bit         done;

  always #5 clk = ~clk;

  logic_reduce_unit #(
    .WIDTH(8), .CNT_W(4), .MAX_BURST(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .op(op), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .out_trunc(out_trunc)
`ifdef LOGIC_REDUCE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  function automatic logic [7:0] gate_m(
    input logic [1:0] o, input logic [7:0] a,
    input logic [7:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Burst-level model: collect per-beat values, fold at burst end
  task automatic model_beat();
    logic [7:0] r;
    res_t x;
    if (!bopen && !mode) begin
      x.d = gate_m(op, in_a, in_b);
      x.c = 4'd1;
      x.t = 1'b0;
      exp_q.push_back(x);
      return;
    end
    if (!bopen) bop = op;
    bopen = 1;
    bq.push_back(gate_m(bop, in_a, in_b));
    if (in_last || bq.size() == 15) begin
      r = bq[0];
      for (int i = 1; i < bq.size(); i++)
        r = (bop == 2'd1) ? (r | bq[i]) :
            (bop == 2'd2) ? (r ^ bq[i]) : (r & bq[i]);
      x.d = r;
      x.c = 4'(bq.size());
      x.t = !in_last;
      exp_q.push_back(x);
      bq.delete();
      bopen = 0;
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      bopen = 0;
      bq.delete();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) model_beat();
      if (out_valid && out_ready) begin
        mon_x = {out_data, out_count, out_trunc};
        got_q.push_back(mon_x);
      end
    end
  end

  task automatic send(
    input logic [7:0] a, input logic [7:0] b,
    input logic l, input logic [1:0] o,
    input logic m, output int waits);
    bit ok;
    ok    = 0;
    waits = 0;
    in_valid = 1; in_a = a; in_b = b;
    in_last = l; op = o; mode = m;
    for (int n = 0; n < 200; n++) begin
      #4;
      ok = in_ready;
      @(negedge clk);
      if (ok) break;
      waits++;
    end
    in_valid = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout in_ready stayed 0, required 1");
    end
  endtask

  task automatic drain();
    out_ready = 1;
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #4;
    cur = {out_data, out_count, out_trunc};
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs valid=%b ready=%b, required 0 0",
               out_valid, in_ready);
    end
    checks++;
    if (cur !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_out got %h, required 0", cur);
    end
`ifdef LOGIC_REDUCE_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_par got %b, required 0", out_parity);
    end
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_elementwise();
    int w;
    res_t e;
    out_ready = 1;
    send(8'hF0, 8'h3C, 0, 2'd0, 0, w);
    e = {8'h30, 4'd1, 1'b0};
    cur = {out_data, out_count, out_trunc};
    checks++;
    if (out_valid !== 1'b1 || cur !== e) begin
      errors++;
      $display("FAIL ew_and valid=%b got %h, required 1 %h",
               out_valid, cur, e);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [1:0] ops [3] = '{2'd1, 2'd2, 2'd3};
    logic [7:0] res [3] = '{8'hAF, 8'hAA, 8'hFA};
    res_t e;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(8'hA5, 8'h0F, 0, ops[i], 0, w);
      e = {res[i], 4'd1, 1'b0};
      cur = {out_data, out_count, out_trunc};
      checks++;
      if (w != 0 || out_valid !== 1'b1 || cur !== e) begin
        errors++;
        $display("FAIL b2b_%0d waits=%0d valid=%b got %h, required 0 1 %h",
                 i, w, out_valid, cur, e);
      end
    end
  endtask

  task automatic test_reduce_xor();
    int w;
    res_t e;
    out_ready = 1;
    send(8'h01, 8'h00, 0, 2'd2, 1, w);
    send(8'h02, 8'h00, 0, 2'd2, 1, w);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL red_mid valid=%b, required 0", out_valid);
    end
    send(8'h04, 8'h00, 1, 2'd2, 1, w);
    e = {8'h07, 4'd3, 1'b0};
    cur = {out_data, out_count, out_trunc};
    checks++;
    if (out_valid !== 1'b1 || cur !== e) begin
      errors++;
      $display("FAIL red_xor valid=%b got %h, required 1 %h",
               out_valid, cur, e);
    end
`ifdef LOGIC_REDUCE_PARITY_EN
    checks++;
    if (out_parity !== 1'b1) begin
      errors++;
      $display("FAIL red_par got %b, required 1", out_parity);
    end
`endif
  endtask

  task automatic test_truncate();
    int w;
    res_t e;
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      send(8'hFF, 8'hFF, (i == 16), 2'd0, 1, w);
      cur = {out_data, out_count, out_trunc};
      if (i == 15) e = {8'hFF, 4'd15, 1'b1};
      if (i == 16) e = {8'hFF, 4'd1, 1'b0};
      if (i >= 15) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== e) begin
          errors++;
          $display("FAIL trunc_%0d valid=%b got %h, required 1 %h",
                   i, out_valid, cur, e);
        end
      end
    end
  endtask

  task automatic test_stall();
    int w;
    res_t e [2];
    drain();
    e[0] = {8'h3C, 4'd1, 1'b0};
    e[1] = {8'h03, 4'd2, 1'b0};
    send(8'h33, 8'h0F, 0, 2'd2, 0, w);
    out_ready = 0;
    in_valid = 1; in_a = 8'h01; in_b = 8'h00;
    in_last = 0; op = 2'd1; mode = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      cur = {out_data, out_count, out_trunc};
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur !== e[0]) begin
        errors++;
        $display("FAIL stall_a%0d rdy=%b valid=%b got %h, required 0 1 %h",
                 i, in_ready, out_valid, cur, e[0]);
      end
      @(negedge clk);
    end
    out_ready = 1;
    send(8'h01, 8'h00, 0, 2'd1, 1, w);
    out_ready = 0;
    send(8'h02, 8'h00, 1, 2'd0, 0, w);
    for (int i = 0; i < 3; i++) begin
      #4;
      cur = {out_data, out_count, out_trunc};
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur !== e[1]) begin
        errors++;
        $display("FAIL stall_b%0d rdy=%b valid=%b got %h, required 0 1 %h",
                 i, in_ready, out_valid, cur, e[1]);
      end
      @(negedge clk);
    end
    out_ready = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL stall_cnt got %0d results, required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== e[i]) begin
          errors++;
          $display("FAIL stall_res%0d got %h, required %h",
                   i, got_q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    res_t e;
    drain();
    send(8'hF0, 8'hFF, 0, 2'd0, 1, w);
    send(8'h3C, 8'hFF, 0, 2'd0, 1, w);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_%0d valid=%b, required 0", i, out_valid);
      end
      @(negedge clk);
    end
    send(8'h07, 8'h00, 1, 2'd2, 1, w);
    e = {8'h07, 4'd1, 1'b0};
    cur = {out_data, out_count, out_trunc};
    checks++;
    if (out_valid !== 1'b1 || cur !== e) begin
      errors++;
      $display("FAIL rstmid_new valid=%b got %h, required 1 %h",
               out_valid, cur, e);
    end
`ifdef LOGIC_REDUCE_PARITY_EN
    checks++;
    if (out_parity !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_par got %b, required 1", out_parity);
    end
`endif
  endtask

  task automatic test_random();
    int w;
    drain();
    done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(8'($urandom), 8'($urandom),
               ($urandom_range(0, 5) == 0),
               2'($urandom), 1'($urandom), w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    out_ready = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_cnt got %0d results, required %0d",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_res%0d got %h, required %h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0;
    in_last = 0; op = 0; mode = 0; out_ready = 0;
    @(negedge clk);
    test_reset();
    test_elementwise();
    test_back_to_back();
    test_reduce_xor();
    test_truncate();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
